exc_commit: RTL and testbench

- Commit-side initiator for the CSR unit; sits at the end of the writeback stage.
- Takes one retiring instruction per handshake, along with its exception flags and CSR-op fields.
- Arbitrates exception vs. interrupt vs. ertn, then drives the CSR file's access and exception/ertn inputs.
- Captures the CSR-supplied target PC and holds a redirect request to IF until IF accepts it, stalling and flushing the pipeline meanwhile.

---
 rtl/exc_commit_pkg.sv | 40 ++++
 rtl/exc_commit_if.sv | 28 ++
 rtl/exc_commit_prio_enc.sv | 45 ++++
 rtl/exc_commit.sv | 107 ++++++++++
 tb/tb_exc_commit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_commit_pkg.sv
// Shared constants and types for the commit-side exception/CSR initiator.
package exc_commit_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [8:0] ESUB_ADEF = 9'd0;
    localparam logic [8:0] ESUB_ADEM = 9'd1;

    // Bit positions inside wb_exc = {adem, ale, brk, sys, ine, adef}
    localparam int EXC_ADEF = 0;
    localparam int EXC_INE  = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_ALE  = 4;
    localparam int EXC_ADEM = 5;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RD   = 2'd1,
        CSR_WR   = 2'd2,
        CSR_XCHG = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        VSEL_ZERO  = 2'd0,
        VSEL_PC    = 2'd1,
        VSEL_VADDR = 2'd2
    } vaddr_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } state_e;

endpackage

// File: rtl/exc_commit_if.sv
// Writeback-to-commit handshake bundle; master is the writeback stage.
interface exc_commit_if #(
    parameter int ADDR_W = 32
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_pc;
    logic [ADDR_W-1:0] wb_vaddr;
    logic [5:0]        wb_exc;
    logic              wb_ertn;
    logic [1:0]        wb_csr_op;
    logic [13:0]       wb_csr_num;
    logic [ADDR_W-1:0] wb_rd_val;
    logic [ADDR_W-1:0] wb_rj_val;
    logic              wb_commit;

    modport master (
        output wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn,
               wb_csr_op, wb_csr_num, wb_rd_val, wb_rj_val,
        input  wb_ready, wb_commit
    );

    modport slave (
        input  wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn,
               wb_csr_op, wb_csr_num, wb_rd_val, wb_rj_val,
        output wb_ready, wb_commit
    );
endinterface

// File: rtl/exc_commit_prio_enc.sv
// Priority encoder: interrupt > adef > ine > sys > brk > ale > adem > ertn.
module exc_prio_enc
    import exc_commit_pkg::*;
(
    input  logic       int_sig,
    input  logic [5:0] exc,
    input  logic       ertn,
    output logic       take,
    output logic       is_ertn,
    output logic [5:0] ecode,
    output logic [8:0] esubcode,
    output vaddr_sel_e vaddr_sel
);

    always_comb begin
        take      = int_sig || (|exc) || ertn;
        is_ertn   = 1'b0;
        ecode     = ECODE_INT;
        esubcode  = ESUB_ADEF;
        vaddr_sel = VSEL_ZERO;
        if (int_sig) begin
            ecode = ECODE_INT;
        end else if (exc[EXC_ADEF]) begin
            ecode     = ECODE_ADE;
            esubcode  = ESUB_ADEF;
            vaddr_sel = VSEL_PC;
        end else if (exc[EXC_INE]) begin
            ecode = ECODE_INE;
        end else if (exc[EXC_SYS]) begin
            ecode = ECODE_SYS;
        end else if (exc[EXC_BRK]) begin
            ecode = ECODE_BRK;
        end else if (exc[EXC_ALE]) begin
            ecode     = ECODE_ALE;
            vaddr_sel = VSEL_VADDR;
        end else if (exc[EXC_ADEM]) begin
            ecode     = ECODE_ADE;
            esubcode  = ESUB_ADEM;
            vaddr_sel = VSEL_VADDR;
        end else if (ertn) begin
            is_ertn = 1'b1;
        end
    end

endmodule

// File: rtl/exc_commit.sv
// Commit-side CSR/exception initiator with held redirect to IF.
// Optional event counters are built when EXC_STAT_EN is defined.
module exc_commit
    import exc_commit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ECODE_W = 6
) (
    input  logic                clk,
    input  logic                resetn,
    exc_commit_if.slave         wb,
    input  logic                int_signal,
    output logic [13:0]         csr_num,
    output logic                csr_we,
    output logic [ADDR_W-1:0]   csr_wdata,
    output logic [ADDR_W-1:0]   csr_wmask,
    output logic                exc_signal,
    output logic                ertn_signal,
    output logic [ECODE_W-1:0]  exc_ecode,
    output logic [8:0]          exc_esubcode,
    output logic [ADDR_W-1:0]   exc_pc,
    output logic [ADDR_W-1:0]   exc_vaddr,
    input  logic [ADDR_W-1:0]   csr_target_pc,
    output logic                flush,
    output logic                redirect_valid,
    output logic [ADDR_W-1:0]   redirect_pc,
    input  logic                redirect_ready,
    output logic [31:0]         exc_count,
    output logic [31:0]         ertn_count
);

    state_e     state, state_nxt;
    logic       take, is_ertn, fire, event_fire;
    logic [5:0] ecode;
    vaddr_sel_e vaddr_sel;

    exc_prio_enc u_prio (
        .int_sig   (int_signal),
        .exc       (wb.wb_exc),
        .ertn      (wb.wb_ertn),
        .take      (take),
        .is_ertn   (is_ertn),
        .ecode     (ecode),
        .esubcode  (exc_esubcode),
        .vaddr_sel (vaddr_sel)
    );

    assign fire       = wb.wb_valid && (state == ST_RUN);
    assign event_fire = fire && take;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (event_fire)     state_nxt = ST_REDIR;
            ST_REDIR: if (redirect_ready) state_nxt = ST_RUN;
            default:                      state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        wb.wb_ready    = (state == ST_RUN);
        wb.wb_commit   = fire && !take;
        exc_signal     = event_fire && !is_ertn;
        ertn_signal    = event_fire && is_ertn;
        flush          = event_fire || (state == ST_REDIR);
        redirect_valid = (state == ST_REDIR);
        csr_we         = fire && !take &&
                         ((wb.wb_csr_op == CSR_WR) || (wb.wb_csr_op == CSR_XCHG));
        csr_wdata      = wb.wb_rd_val;
        csr_wmask      = (wb.wb_csr_op == CSR_XCHG) ? wb.wb_rj_val : '1;
        csr_num        = wb.wb_csr_num;
        exc_ecode      = ECODE_W'(ecode);
        exc_pc         = wb.wb_pc;
        case (vaddr_sel)
            VSEL_PC:    exc_vaddr = wb.wb_pc;
            VSEL_VADDR: exc_vaddr = wb.wb_vaddr;
            default:    exc_vaddr = '0;
        endcase
    end

    // The CSR target is only valid during the pulse cycle, so it is captured then.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         redirect_pc <= '0;
        else if (event_fire) redirect_pc <= csr_target_pc;
    end

`ifdef EXC_STAT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_count  <= '0;
            ertn_count <= '0;
        end else begin
            if (exc_signal && (exc_count != '1))   exc_count  <= exc_count + 32'd1;
            if (ertn_signal && (ertn_count != '1)) ertn_count <= ertn_count + 32'd1;
        end
    end
`else
    assign exc_count  = '0;
    assign ertn_count = '0;
`endif

endmodule

// File: tb/tb_exc_commit.sv
// Directed self-checking bench for exc_commit.
module tb_exc_commit;
    import exc_commit_pkg::*;

    logic        clk;
    logic        resetn;
    logic        int_signal;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wdata, csr_wmask;
    logic        exc_signal, ertn_signal;
    logic [5:0]  exc_ecode;
    logic [8:0]  exc_esubcode;
    logic [31:0] exc_pc, exc_vaddr, csr_target_pc;
    logic        flush, redirect_valid, redirect_ready;
    logic [31:0] redirect_pc, exc_count, ertn_count;

    int vectors;
    int miscompares;

    exc_commit_if #(.ADDR_W(32)) wb ();

    exc_commit #(.ADDR_W(32), .ECODE_W(6)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb             (wb.slave),
        .int_signal     (int_signal),
        .csr_num        (csr_num),
        .csr_we         (csr_we),
        .csr_wdata      (csr_wdata),
        .csr_wmask      (csr_wmask),
        .exc_signal     (exc_signal),
        .ertn_signal    (ertn_signal),
        .exc_ecode      (exc_ecode),
        .exc_esubcode   (exc_esubcode),
        .exc_pc         (exc_pc),
        .exc_vaddr      (exc_vaddr),
        .csr_target_pc  (csr_target_pc),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .exc_count      (exc_count),
        .ertn_count     (ertn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb.wb_valid    = 1'b0;
        wb.wb_pc       = '0;
        wb.wb_vaddr    = '0;
        wb.wb_exc      = '0;
        wb.wb_ertn     = 1'b0;
        wb.wb_csr_op   = CSR_NONE;
        wb.wb_csr_num  = '0;
        wb.wb_rd_val   = '0;
        wb.wb_rj_val   = '0;
        int_signal     = 1'b0;
        csr_target_pc  = '0;
        redirect_ready = 1'b0;
    endtask

    // Leave REDIR with the bus idle; one cycle with redirect_ready high.
    task automatic release_redirect();
        clear_inputs();
        redirect_ready = 1'b1;
        #2;
        check_output("redir_valid_before_accept", redirect_valid, 1);
        tick();
        redirect_ready = 1'b0;
        #2;
        check_output("back_in_run_ready", wb.wb_ready, 1);
        check_output("back_in_run_redir_valid", redirect_valid, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        resetn = 1'b0;
        #12;
        check_output("rst_ready", wb.wb_ready, 1);
        check_output("rst_redir_valid", redirect_valid, 0);
        check_output("rst_redir_pc", redirect_pc, 0);
        check_output("rst_flush", flush, 0);
        check_output("rst_exc_signal", exc_signal, 0);
        tick();
        resetn = 1'b1;
        tick();

        // csrxchg with a partial mask
        wb.wb_valid = 1'b1; wb.wb_csr_op = CSR_XCHG; wb.wb_csr_num = 14'h30;
        wb.wb_rd_val = 32'hAAAA5555; wb.wb_rj_val = 32'h0000FFFF;
        #2;
        check_output("xchg_we", csr_we, 1);
        check_output("xchg_wdata", csr_wdata, 32'hAAAA5555);
        check_output("xchg_wmask", csr_wmask, 32'h0000FFFF);
        check_output("xchg_commit", wb.wb_commit, 1);
        check_output("xchg_csr_num", csr_num, 32'h30);
        check_output("xchg_flush", flush, 0);
        tick();

        // csrwr uses a full mask, csrrd writes nothing
        wb.wb_csr_op = CSR_WR; wb.wb_rd_val = 32'h12345678;
        #2;
        check_output("csrwr_we", csr_we, 1);
        check_output("csrwr_wmask", csr_wmask, 32'hFFFFFFFF);
        tick();
        wb.wb_csr_op = CSR_RD;
        #2;
        check_output("csrrd_we", csr_we, 0);
        check_output("csrrd_commit", wb.wb_commit, 1);
        tick();

        // No valid: exception flags must not produce anything
        clear_inputs();
        wb.wb_exc = 6'b000100; wb.wb_csr_op = CSR_WR;
        #2;
        check_output("idle_exc_signal", exc_signal, 0);
        check_output("idle_commit", wb.wb_commit, 0);
        check_output("idle_we", csr_we, 0);
        check_output("idle_flush", flush, 0);
        tick();

        // syscall (exception #1)
        clear_inputs();
        wb.wb_valid = 1'b1; wb.wb_exc = 6'b000100; wb.wb_pc = 32'h1C000100;
        csr_target_pc = 32'h1C008000;
        #2;
        check_output("sys_exc_signal", exc_signal, 1);
        check_output("sys_ertn_signal", ertn_signal, 0);
        check_output("sys_ecode", exc_ecode, 32'h0B);
        check_output("sys_exc_pc", exc_pc, 32'h1C000100);
        check_output("sys_vaddr", exc_vaddr, 0);
        check_output("sys_flush", flush, 1);
        check_output("sys_commit", wb.wb_commit, 0);
        check_output("sys_redir_valid_same_cycle", redirect_valid, 0);
        tick();
        wb.wb_exc = '0; wb.wb_csr_op = CSR_WR; csr_target_pc = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_output("hold_redir_valid", redirect_valid, 1);
            check_output("hold_redir_pc", redirect_pc, 32'h1C008000);
            check_output("hold_ready", wb.wb_ready, 0);
            check_output("hold_flush", flush, 1);
            check_output("hold_exc_signal", exc_signal, 0);
            check_output("hold_we", csr_we, 0);
            check_output("hold_commit", wb.wb_commit, 0);
            tick();
        end
        release_redirect();

        // ALE together with interrupt: interrupt wins (exception #2)
        wb.wb_valid = 1'b1; wb.wb_exc = 6'b010000; wb.wb_vaddr = 32'h00000003;
        wb.wb_csr_op = CSR_WR; int_signal = 1'b1; csr_target_pc = 32'h1C001000;
        #2;
        check_output("int_ale_exc_signal", exc_signal, 1);
        check_output("int_ale_ecode", exc_ecode, 32'h00);
        check_output("int_ale_vaddr", exc_vaddr, 0);
        check_output("int_ale_we", csr_we, 0);
        tick();

        // Interrupt rising in REDIR is held off until the next fire (exception #3)
        clear_inputs();
        int_signal = 1'b1; wb.wb_valid = 1'b1;
        #2;
        check_output("redir_int_exc_signal", exc_signal, 0);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        #2;
        check_output("post_redir_int_exc_signal", exc_signal, 1);
        check_output("post_redir_int_ecode", exc_ecode, 32'h00);
        tick();
        release_redirect();

        // ADEM on a csrxchg (exception #4)
        wb.wb_valid = 1'b1; wb.wb_exc = 6'b100000; wb.wb_vaddr = 32'h80000001;
        wb.wb_csr_op = CSR_XCHG;
        #2;
        check_output("adem_ecode", exc_ecode, 32'h08);
        check_output("adem_esub", exc_esubcode, 1);
        check_output("adem_vaddr", exc_vaddr, 32'h80000001);
        check_output("adem_we", csr_we, 0);
        tick();
        release_redirect();

        // ADEF also flagged with SYS: ADEF wins (exception #5)
        wb.wb_valid = 1'b1; wb.wb_exc = 6'b000101; wb.wb_pc = 32'h1C000002;
        wb.wb_vaddr = 32'h55555555;
        #2;
        check_output("adef_ecode", exc_ecode, 32'h08);
        check_output("adef_esub", exc_esubcode, 0);
        check_output("adef_vaddr", exc_vaddr, 32'h1C000002);
        tick();
        release_redirect();

        // ertn #1
        wb.wb_valid = 1'b1; wb.wb_ertn = 1'b1; csr_target_pc = 32'h1C000200;
        #2;
        check_output("ertn_signal", ertn_signal, 1);
        check_output("ertn_exc_signal", exc_signal, 0);
        check_output("ertn_flush", flush, 1);
        tick();
        #2;
        check_output("ertn_redir_pc", redirect_pc, 32'h1C000200);
        release_redirect();

        // ertn #2, then reset while in REDIR
        wb.wb_valid = 1'b1; wb.wb_ertn = 1'b1; csr_target_pc = 32'h1C000300;
        tick();
        clear_inputs();
        #2;
        check_output("ertn2_redir_valid", redirect_valid, 1);
`ifdef EXC_STAT_EN
        check_output("exc_count", exc_count, 5);
        check_output("ertn_count", ertn_count, 2);
`else
        check_output("exc_count", exc_count, 0);
        check_output("ertn_count", ertn_count, 0);
`endif
        resetn = 1'b0;
        #1;
        check_output("midreset_redir_valid", redirect_valid, 0);
        check_output("midreset_flush", flush, 0);
        check_output("midreset_redir_pc", redirect_pc, 0);
        check_output("midreset_ready", wb.wb_ready, 1);
        check_output("midreset_exc_count", exc_count, 0);
        tick();
        resetn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
